// File: rtl/demux_1x4.sv
// demux_1x4: drains a show-ahead input FIFO and routes each word to one of
// four output FIFOs, selected by the word's two MSBs. Per-destination
// almost-full backpressure stalls the head word; push/out_data are registered.
// Optional macro DEMUX_COUNT_EN adds per-destination routed-word counters.
module demux_1x4 #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  in_pop,
  input  logic [3:0]            almost_full,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            push,
  output logic [1:0]            state
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_0,
  output logic [CNT_WIDTH-1:0]  cnt_1,
  output logic [CNT_WIDTH-1:0]  cnt_2,
  output logic [CNT_WIDTH-1:0]  cnt_3
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FORWARD = 2'b01,
    HOLD    = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            push_q, push_d;
  logic [1:0]            dest;
  logic                  go;

  assign dest = in_data[DATA_WIDTH-1 -: 2];
  assign go   = enable & ~in_empty & ~almost_full[dest];

  // Pop strobe; IDLE with enable=1 may pop in the same cycle it leaves IDLE.
  // Held low during reset so upstream never loses a word that is then dropped.
  assign in_pop = ~reset & ((state_q != IDLE) | enable) & go;

  // Next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    push_d  = 4'b0000;
    if (in_pop) begin
      data_d = in_data;
      push_d = 4'b0001 << dest;
    end
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FORWARD;
        FORWARD: if (!in_empty && almost_full[dest]) state_d = HOLD;
        HOLD:    if (!almost_full[dest])             state_d = FORWARD;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset suppresses any push from this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      push_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      push_q  <= push_d;
    end
  end

  assign out_data = data_q;
  assign push     = push_q;
  assign state    = state_q;

`ifdef DEMUX_COUNT_EN
  logic [3:0][CNT_WIDTH-1:0] cnt_q;

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    // Counter steps on the same edge that raises push[i]; wraps naturally.
    always_ff @(posedge clk) begin
      if (reset)          cnt_q[i] <= '0;
      else if (push_d[i]) cnt_q[i] <= cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_0 = cnt_q[0];
  assign cnt_1 = cnt_q[1];
  assign cnt_2 = cnt_q[2];
  assign cnt_3 = cnt_q[3];
`else
  // Counters not built; keep the width parameter referenced.
  if (CNT_WIDTH < 1) begin : g_cnt_width_chk
  end
`endif

endmodule

// File: tb/tb_demux_1x4.sv
// Directed self-checking bench for demux_1x4 (counter checks only when
// DEMUX_COUNT_EN is defined; counters built 2 bits wide to exercise wrap).
module tb_demux_1x4;
  localparam int DW = 10;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset, enable, in_empty, in_pop;
  logic [DW-1:0] in_data, out_data;
  logic [3:0]    almost_full, push;
  logic [1:0]    state;
`ifdef DEMUX_COUNT_EN
  logic [CW-1:0] cnt_0, cnt_1, cnt_2, cnt_3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  demux_1x4 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_empty(in_empty), .in_pop(in_pop), .almost_full(almost_full),
    .out_data(out_data), .push(push), .state(state)
`ifdef DEMUX_COUNT_EN
    , .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] w4 [4] = '{10'b1111000000, 10'b0011100100, 10'b1011100111, 10'b0100011011};
  logic [3:0]    p4 [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
  logic [DW-1:0] w5 [5] = '{10'b0000000001, 10'b0100000010, 10'b1000000011,
                            10'b1100000100, 10'b0000000101};
  logic [3:0]    p5 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]    c3 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset = 1'b1; enable = 1'b1; in_empty = 1'b0; almost_full = 4'b0000;
    in_data = w4[0];

    // Reset held two cycles with a valid head word and enable high.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_pop",   in_pop,   0);
      chk("rst_push",  push,     4'b0000);
      chk("rst_data",  out_data, 0);
      chk("rst_state", state,    2'b00);
    end

    // Back-to-back routing of four words, one per class.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = w4[i];
      #1 chk("b2b_pop", in_pop, 1);
      tick();
      chk("b2b_push",  push,     p4[i]);
      chk("b2b_data",  out_data, w4[i]);
      chk("b2b_state", state,    2'b01);
    end

    // Empty input in FORWARD: no pop, no push, data held.
    in_empty = 1'b1;
    #1 chk("empty_pop", in_pop, 0);
    tick();
    chk("empty_push",  push,     4'b0000);
    chk("empty_state", state,    2'b01);
    chk("empty_hold",  out_data, w4[3]);

    // Addressed FIFO almost full -> HOLD, then release.
    in_empty = 1'b0; in_data = 10'b1011100111; almost_full = 4'b0100;
    #1 chk("hold_pop0", in_pop, 0);
    tick();
    chk("hold_state", state, 2'b10);
    chk("hold_push",  push,  4'b0000);
    chk("hold_pop1",  in_pop, 0);
    almost_full = 4'b0000;
    #1 chk("rel_pop", in_pop, 1);
    tick();
    chk("rel_push",  push,     4'b0100);
    chk("rel_state", state,    2'b01);
    chk("rel_data",  out_data, 10'b1011100111);

    // Only the addressed FIFO blocks.
    in_data = 10'b0100011011; almost_full = 4'b0100;
    #1 chk("other_pop", in_pop, 1);
    tick();
    chk("other_push",  push,  4'b0010);
    chk("other_state", state, 2'b01);
    almost_full = 4'b0000;

    // Five-word stream, enable dropped after the second pop.
    for (int i = 0; i < 2; i++) begin
      in_data = w5[i];
      tick();
      chk("s5a_push", push, p5[i]);
    end
    enable = 1'b0; in_data = w5[2];
    #1 chk("dis_pop", in_pop, 0);
    tick();
    chk("dis_push",  push,  4'b0000);
    chk("dis_state", state, 2'b00);
    tick();
    chk("dis_push2", push,     4'b0000);
    chk("dis_data",  out_data, w5[1]);
    enable = 1'b1;
    for (int i = 2; i < 5; i++) begin
      in_data = w5[i];
      #1 chk("s5b_pop", in_pop, 1);
      tick();
      chk("s5b_push", push,     p5[i]);
      chk("s5b_data", out_data, w5[i]);
    end

    // Reset mid-stream: popping suppressed, registers cleared.
    reset = 1'b1; in_data = 10'b1100000000;
    #1 chk("mrst_pop", in_pop, 0);
    tick();
    chk("mrst_push",  push,     4'b0000);
    chk("mrst_data",  out_data, 0);
    chk("mrst_state", state,    2'b00);

`ifdef DEMUX_COUNT_EN
    // Five pushes to destination 3 with 2-bit counters: wrap after 3.
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("cnt_push", push,  4'b1000);
      chk("cnt_3",    cnt_3, c3[k]);
      chk("cnt_0",    cnt_0, 0);
      chk("cnt_1",    cnt_1, 0);
      chk("cnt_2",    cnt_2, 0);
    end
    reset = 1'b1;
    tick();
    chk("cnt_rst3", cnt_3, 0);
    chk("cnt_rst0", cnt_0, 0);
`else
    if (c3[0] != 2'd1) $display("counter table unexpected");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
